// File: rtl/vga_vram_arbiter_if.sv
// Bus bundle between the VGA VRAM arbiter and its CPU, display-fetch and RAM neighbours.
// The slave modport is the arbiter's view; master is everything around it.
interface vga_vram_arbiter_if #(
  parameter int ADDR_WIDTH = 13
);
  logic                  cs;
  logic [19:1]           data_m_addr;
  logic [15:0]           data_m_data_in;
  logic [15:0]           data_m_data_out;
  logic [1:0]            data_m_bytesel;
  logic                  data_m_wr_en;
  logic                  data_m_access;
  logic                  data_m_ack;

  logic                  fetch_req;
  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic                  fetch_gnt;
  logic                  fetch_rvalid;
  logic [15:0]           fetch_rdata;

  logic [ADDR_WIDTH-1:0] vram_addr;
  logic                  vram_wr_en;
  logic [1:0]            vram_be;
  logic [15:0]           vram_wdata;
  logic [15:0]           vram_rdata;

  modport slave (
    input  cs, data_m_addr, data_m_data_in, data_m_bytesel, data_m_wr_en, data_m_access,
    input  fetch_req, fetch_addr, vram_rdata,
    output data_m_data_out, data_m_ack, fetch_gnt, fetch_rvalid, fetch_rdata,
    output vram_addr, vram_wr_en, vram_be, vram_wdata
  );

  modport master (
    output cs, data_m_addr, data_m_data_in, data_m_bytesel, data_m_wr_en, data_m_access,
    output fetch_req, fetch_addr, vram_rdata,
    input  data_m_data_out, data_m_ack, fetch_gnt, fetch_rvalid, fetch_rdata,
    input  vram_addr, vram_wr_en, vram_be, vram_wdata
  );
endinterface

// File: rtl/vga_vram_arbiter.sv
// Single-port VRAM arbiter: display fetch has deadline priority, the CPU is
// guaranteed a slot after at most STARVE_LIMIT fetch grants. Fixed 3-cycle completion.
module vga_vram_arbiter #(
  parameter int ADDR_WIDTH   = 13,
  parameter int STARVE_LIMIT = 4
) (
  input logic               clk,
  input logic               reset,
  vga_vram_arbiter_if.slave bus
);
  localparam int DATA_W = 16;
  localparam int CNT_W  = 4;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    TAG_NONE   = 2'd0,
    TAG_FETCH  = 2'd1,
    TAG_CPU_RD = 2'd2,
    TAG_CPU_WR = 2'd3
  } tag_e;

  logic                  cpu_pending;
  logic                  fetch_ok;
  logic                  gnt_fetch;
  logic                  gnt_cpu;
  logic [ADDR_WIDTH-1:0] cpu_addr;

  logic                  cpu_inflight_q, cpu_inflight_d;
  logic [CNT_W-1:0]      starve_cnt_q, starve_cnt_d;
  tag_e                  tag_p1_q, tag_p1_d;
  tag_e                  tag_p2_q, tag_p2_d;

  logic [ADDR_WIDTH-1:0] vram_addr_q, vram_addr_d;
  logic                  vram_wr_en_q, vram_wr_en_d;
  logic [1:0]            vram_be_q, vram_be_d;
  logic [DATA_W-1:0]     vram_wdata_q, vram_wdata_d;

  logic                  ack_q, ack_d;
  logic [DATA_W-1:0]     data_out_q, data_out_d;
  logic                  fetch_rvalid_q, fetch_rvalid_d;
  logic [DATA_W-1:0]     fetch_rdata_q, fetch_rdata_d;

  assign cpu_addr = bus.data_m_addr[ADDR_WIDTH:1];

  // Upper CPU address bits beyond the VRAM window simply wrap.
  if (ADDR_WIDTH < 19) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.data_m_addr[19:ADDR_WIDTH+1];
  end

  always_comb begin
    cpu_pending    = bus.cs & bus.data_m_access & ~cpu_inflight_q & ~ack_q;
    fetch_ok       = bus.fetch_req & (~cpu_pending | (starve_cnt_q < LIMIT));
    // No grants while reset is held so every output reads zero during reset.
    gnt_fetch      = reset & fetch_ok;
    gnt_cpu        = reset & ~fetch_ok & cpu_pending;

    starve_cnt_d   = starve_cnt_q;
    if (!cpu_pending || gnt_cpu) begin
      starve_cnt_d = '0;
    end else if (gnt_fetch && (starve_cnt_q != '1)) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end

    cpu_inflight_d = cpu_inflight_q;
    if (gnt_cpu) begin
      cpu_inflight_d = 1'b1;
    end else if (ack_q) begin
      cpu_inflight_d = 1'b0;
    end

    // Grant stage: select the winner's access onto the registered RAM port.
    tag_p1_d     = TAG_NONE;
    vram_addr_d  = vram_addr_q;
    vram_wr_en_d = 1'b0;
    vram_be_d    = vram_be_q;
    vram_wdata_d = vram_wdata_q;
    if (gnt_fetch) begin
      tag_p1_d     = TAG_FETCH;
      vram_addr_d  = bus.fetch_addr;
    end else if (gnt_cpu) begin
      tag_p1_d     = bus.data_m_wr_en ? TAG_CPU_WR : TAG_CPU_RD;
      vram_addr_d  = cpu_addr;
      vram_wr_en_d = bus.data_m_wr_en;
      vram_be_d    = bus.data_m_bytesel;
      vram_wdata_d = bus.data_m_data_in;
    end

    // RAM stage: tag follows the access while the RAM produces read data.
    tag_p2_d = tag_p1_q;

    // Completion stage: route captured RAM data to the requester that owns it.
    ack_d          = (tag_p2_q == TAG_CPU_RD) || (tag_p2_q == TAG_CPU_WR);
    data_out_d     = (tag_p2_q == TAG_CPU_RD) ? bus.vram_rdata : '0;
    fetch_rvalid_d = (tag_p2_q == TAG_FETCH);
    fetch_rdata_d  = (tag_p2_q == TAG_FETCH) ? bus.vram_rdata : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_inflight_q <= 1'b0;
      starve_cnt_q   <= '0;
      tag_p1_q       <= TAG_NONE;
      tag_p2_q       <= TAG_NONE;
      vram_addr_q    <= '0;
      vram_wr_en_q   <= 1'b0;
      vram_be_q      <= '0;
      vram_wdata_q   <= '0;
      ack_q          <= 1'b0;
      data_out_q     <= '0;
      fetch_rvalid_q <= 1'b0;
      fetch_rdata_q  <= '0;
    end else begin
      cpu_inflight_q <= cpu_inflight_d;
      starve_cnt_q   <= starve_cnt_d;
      tag_p1_q       <= tag_p1_d;
      tag_p2_q       <= tag_p2_d;
      vram_addr_q    <= vram_addr_d;
      vram_wr_en_q   <= vram_wr_en_d;
      vram_be_q      <= vram_be_d;
      vram_wdata_q   <= vram_wdata_d;
      ack_q          <= ack_d;
      data_out_q     <= data_out_d;
      fetch_rvalid_q <= fetch_rvalid_d;
      fetch_rdata_q  <= fetch_rdata_d;
    end
  end

  assign bus.fetch_gnt       = gnt_fetch;
  assign bus.vram_addr       = vram_addr_q;
  assign bus.vram_wr_en      = vram_wr_en_q;
  assign bus.vram_be         = vram_be_q;
  assign bus.vram_wdata      = vram_wdata_q;
  assign bus.data_m_ack      = ack_q;
  assign bus.data_m_data_out = data_out_q;
  assign bus.fetch_rvalid    = fetch_rvalid_q;
  assign bus.fetch_rdata     = fetch_rdata_q;

endmodule
